// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: bus word, arbiter FSM states and arbiter defaults.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        DONE
    } arb_state_t;

    localparam int unsigned MAX_DSTREAK_DEFAULT = 4;
    localparam int unsigned TIMEOUT_DEFAULT     = 64;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the memory arbiter ports: requester side, RAM side and error flag.
interface memory_arbiter_if
    import cpu_types_pkg::*;
(
    input logic CLK
);

    logic  RST;
    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  ihit;
    word_t imemload;
    logic  dhit;
    word_t dmemload;
    logic  ram_ren;
    logic  ram_wen;
    word_t ram_addr;
    word_t ram_store;
    word_t ram_load;
    logic  ram_rdy;
    logic  arb_err;

    modport arb (
        input  CLK, RST, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               ram_load, ram_rdy,
        output ihit, imemload, dhit, dmemload, ram_ren, ram_wen, ram_addr, ram_store,
               arb_err
    );

    modport tb (
        input  CLK, ihit, imemload, dhit, dmemload, ram_ren, ram_wen, ram_addr,
               ram_store, arb_err,
        output RST, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               ram_load, ram_rdy
    );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with a
// bounded data streak against instruction starvation and an access timeout.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEFAULT,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output logic  ihit,
    output word_t imemload,
    output logic  dhit,
    output word_t dmemload,
    output logic  ram_ren,
    output logic  ram_wen,
    output word_t ram_addr,
    output word_t ram_store,
    input  word_t ram_load,
    input  logic  ram_rdy,
    output logic  arb_err
);

    localparam int unsigned SW = (MAX_DSTREAK > 1) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic [TW-1:0] to_cnt;
    logic          dreq;
    logic          ifirst;

    assign dreq   = dmemREN | dmemWEN;
    assign ifirst = imemREN && (streak == STREAK_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            streak    <= '0;
            to_cnt    <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            imemload  <= '0;
            dmemload  <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            arb_err   <= 1'b0;
        end else begin
            // Hits and load data live for exactly one cycle; no stale data leaks out.
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (!imemREN) begin
                        streak <= '0;
                    end
                    if (dreq && !ifirst) begin
                        state     <= DACC;
                        ram_addr  <= dmemaddr;
                        ram_wen   <= dmemWEN;
                        ram_ren   <= ~dmemWEN;
                        ram_store <= dmemWEN ? dmemstore : '0;
                        // ifirst is false here, so streak < STREAK_MAX: saturation holds.
                        if (imemREN) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (imemREN) begin
                        state     <= IACC;
                        streak    <= '0;
                        ram_addr  <= imemaddr;
                        ram_ren   <= 1'b1;
                        ram_wen   <= 1'b0;
                        ram_store <= '0;
                    end
                end
                IACC, DACC: begin
                    if (ram_rdy) begin
                        state   <= DONE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        if (state == IACC) begin
                            ihit     <= 1'b1;
                            imemload <= ram_load;
                        end else begin
                            dhit     <= 1'b1;
                            dmemload <= ram_wen ? '0 : ram_load;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= IDLE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        arb_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a latency-programmable RAM model and
// per-requester expected-load scoreboards.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if bus (.CLK(clk));

    memory_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK       (bus.CLK),
        .RST       (bus.RST),
        .imemREN   (bus.imemREN),
        .imemaddr  (bus.imemaddr),
        .dmemREN   (bus.dmemREN),
        .dmemWEN   (bus.dmemWEN),
        .dmemaddr  (bus.dmemaddr),
        .dmemstore (bus.dmemstore),
        .ihit      (bus.ihit),
        .imemload  (bus.imemload),
        .dhit      (bus.dhit),
        .dmemload  (bus.dmemload),
        .ram_ren   (bus.ram_ren),
        .ram_wen   (bus.ram_wen),
        .ram_addr  (bus.ram_addr),
        .ram_store (bus.ram_store),
        .ram_load  (bus.ram_load),
        .ram_rdy   (bus.ram_rdy),
        .arb_err   (bus.arb_err)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    word_t       iq[$];
    word_t       dq[$];
    word_t       mem[word_t];
    int unsigned lat    = 1;
    bit          stall  = 1'b0;
    bit          in_acc = 1'b0;
    int unsigned acc_cnt = 0;
    string       grants = "";
    string       hits   = "";
    bit          auto_drop = 1'b1;
    int unsigned cyc = 0;
    int unsigned nhits = 0;
    int unsigned ren_cycles = 0;
    int unsigned wen_cycles = 0;
    bit          prev_strobe = 1'b0;
    word_t       prev_addr = '0;

    function automatic word_t rd(word_t a);
        return mem.exists(a) ? mem[a] : ((a ^ 32'hA5A5_0000) + 32'h1);
    endfunction

    // RAM model: ram_rdy after `lat` access cycles; load is garbage unless valid.
    always @(negedge clk) begin
        if (bus.ram_ren || bus.ram_wen) begin
            if (in_acc) acc_cnt++;
            else begin
                in_acc  = 1'b1;
                acc_cnt = 0;
            end
            bus.ram_rdy  = !stall && (acc_cnt + 1 >= lat);
            bus.ram_load = !bus.ram_rdy ? 32'h5555_5555 :
                           (bus.ram_ren ? rd(bus.ram_addr) : 32'hFFFF_FFFF);
            if (bus.ram_rdy && bus.ram_wen) mem[bus.ram_addr] = bus.ram_store;
        end else begin
            in_acc       = 1'b0;
            bus.ram_rdy  = 1'b0;
            bus.ram_load = 32'h5555_5555;
        end
    end

    task automatic check(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_s(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) passed++;
        else $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    endtask

    task automatic tick();
        logic strobe;
        @(posedge clk);
        #1;
        cyc++;
        strobe = bus.ram_ren | bus.ram_wen;
        if (strobe && prev_strobe) check("addr_stable", bus.ram_addr, prev_addr);
        if (strobe && !prev_strobe) begin
            if (bus.imemREN && !bus.ram_wen && bus.ram_addr == bus.imemaddr) grants = {grants, "I"};
            else grants = {grants, "D"};
        end
        if (bus.ram_ren) ren_cycles++;
        if (bus.ram_wen) begin
            wen_cycles++;
            check("store_val", bus.ram_store, bus.dmemstore);
        end
        prev_strobe = strobe;
        prev_addr   = bus.ram_addr;
        check("no_stale_load",
              word_t'({30'b0, (bus.ihit || bus.imemload == '0), (bus.dhit || bus.dmemload == '0)}),
              32'h3);
        if (bus.ihit) begin
            nhits++;
            hits = {hits, "I"};
            check("ihit_expected", word_t'(iq.size() > 0), 32'h1);
            if (iq.size() > 0) check("imemload", bus.imemload, iq.pop_front());
            if (auto_drop) bus.imemREN = 1'b0;
        end
        if (bus.dhit) begin
            nhits++;
            hits = {hits, "D"};
            check("dhit_expected", word_t'(dq.size() > 0), 32'h1);
            if (dq.size() > 0) check("dmemload", bus.dmemload, dq.pop_front());
            if (auto_drop) begin
                bus.dmemREN = 1'b0;
                bus.dmemWEN = 1'b0;
            end
        end
    endtask

    task automatic wait_hits(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned start = nhits;
        int unsigned k = 0;
        while (nhits - start < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_hits"}, nhits - start, n);
        bus.imemREN = 1'b0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        int unsigned k = 0;
        while (!(bus.ram_ren || bus.ram_wen) && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_strobe_seen"}, word_t'(bus.ram_ren | bus.ram_wen), 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, word_t'({bus.ihit, bus.dhit, bus.ram_ren, bus.ram_wen, bus.arb_err}), '0);
        check({tag, "_addr"}, bus.ram_addr, '0);
        check({tag, "_data"}, bus.imemload | bus.dmemload | bus.ram_store, '0);
    endtask

    initial begin
        int unsigned t0;
        int unsigned n;
        int unsigned h0;

        mem[32'h40]   = 32'h2402_000A;
        bus.RST       = 1'b1;
        bus.imemREN   = 1'b0;
        bus.imemaddr  = '0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        tick();
        tick();
        check_all_zero("reset");
        bus.RST = 1'b0;
        repeat (2) tick();

        // 1: lone instruction fetch, single-cycle RAM
        lat = 1;
        ren_cycles = 0;
        bus.imemaddr = 32'h40;
        bus.imemREN  = 1'b1;
        iq.push_back(32'h2402_000A);
        t0 = cyc;
        n = 0;
        while (!bus.ihit && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", cyc - t0, 32'd2);
        repeat (3) tick();
        check("t1_ren_cycles", ren_cycles, 32'd1);
        check("t1_iq_empty", iq.size(), 32'd0);

        // 2: simultaneous requests, data first, 2-cycle RAM
        lat = 2;
        grants = "";
        hits = "";
        bus.imemaddr = 32'h44;
        bus.imemREN  = 1'b1;
        bus.dmemaddr = 32'h200;
        bus.dmemREN  = 1'b1;
        iq.push_back(rd(32'h44));
        dq.push_back(rd(32'h200));
        wait_hits(2, 40, "t2");
        check_s("t2_grants", grants, "DI");
        check_s("t2_hits", hits, "DI");
        repeat (2) tick();

        // 3: data write
        ren_cycles = 0;
        wen_cycles = 0;
        bus.dmemaddr  = 32'h100;
        bus.dmemstore = 32'hDEAD_BEEF;
        bus.dmemWEN   = 1'b1;
        dq.push_back(32'h0);
        wait_hits(1, 20, "t3");
        check("t3_wen_cycles", wen_cycles, 32'd2);
        check("t3_ren_cycles", ren_cycles, 32'd0);
        check("t3_mem", rd(32'h100), 32'hDEAD_BEEF);
        repeat (2) tick();

        // 4: continuous data pressure with a pending fetch
        lat = 1;
        auto_drop = 1'b0;
        grants = "";
        bus.imemaddr = 32'h80;
        bus.dmemaddr = 32'h300;
        bus.imemREN  = 1'b1;
        bus.dmemREN  = 1'b1;
        repeat (8) dq.push_back(rd(32'h300));
        repeat (2) iq.push_back(rd(32'h80));
        wait_hits(10, 200, "t4");
        auto_drop = 1'b1;
        check_s("t4_grants", grants, "DDDDIDDDDI");
        repeat (3) tick();
        check("t4_queues_empty", iq.size() + dq.size(), 32'd0);

        // 5: RAM never ready -> timeout, sticky error, retry
        stall = 1'b1;
        bus.dmemaddr = 32'h400;
        bus.dmemREN  = 1'b1;
        dq.push_back(rd(32'h400));
        h0 = nhits;
        wait_strobe("t5");
        n = 0;
        while (bus.ram_ren && n < 100) begin
            n++;
            tick();
        end
        check("t5_access_cycles", n, 32'd8);
        check("t5_err_set", word_t'(bus.arb_err), 32'h1);
        check("t5_no_hit", nhits - h0, 32'd0);
        tick();
        check("t5_retry", word_t'(bus.ram_ren), 32'h1);
        check("t5_err_sticky", word_t'(bus.arb_err), 32'h1);
        stall = 1'b0;
        wait_hits(1, 20, "t5");
        check("t5_err_after_hit", word_t'(bus.arb_err), 32'h1);
        bus.RST = 1'b1;
        tick();
        bus.RST = 1'b0;
        check("t5_err_cleared", word_t'(bus.arb_err), 32'h0);
        repeat (2) tick();

        // 6: reset pulse mid-access, request re-served from scratch
        lat = 3;
        bus.dmemaddr = 32'h500;
        bus.dmemREN  = 1'b1;
        dq.push_back(rd(32'h500));
        h0 = nhits;
        wait_strobe("t6");
        bus.RST = 1'b1;
        tick();
        bus.RST = 1'b0;
        check_all_zero("t6_rst");
        check("t6_no_hit", nhits - h0, 32'd0);
        wait_hits(1, 30, "t6");
        repeat (3) tick();
        check("final_queues_empty", iq.size() + dq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
